// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the sequential Q-format divider: defaults, FSM encoding
// and saturation limits.
package qdiv_seq_pkg;

  localparam int Q_DEF = 18;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [N_DEF-1:0] QMAX = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] QMIN = {1'b1, {(N_DEF-1){1'b0}}};

endpackage

// File: rtl/qdiv_seq_absval.sv
// Two's complement to sign + unsigned magnitude; the most negative input maps
// to 2^(N-1) exactly.
module q_absval
  import qdiv_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] x_i,
  output logic [N-1:0] mag_o,
  output logic         sign_o
);

  assign sign_o = x_i[N-1];
  assign mag_o  = sign_o ? (~x_i + 1'b1) : x_i;

endmodule

// File: rtl/qdiv_seq.sv
// Sign-magnitude restoring divider for signed Q-format words, one quotient bit
// per clock, with saturation and divide-by-zero flags.
module qdiv_seq
  import qdiv_seq_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_quotient,
  output logic         o_ovr,
  output logic         o_dbz
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  localparam logic [N-1:0] SAT_P = (N == N_DEF) ? N'(QMAX) : {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_N = (N == N_DEF) ? N'(QMIN) : {1'b1, {(N-1){1'b0}}};

  state_e        state_q, state_d;
  logic [W-1:0]  dvd_q, dvd_d;   // dividend shifts out the top, quotient bits shift in at the bottom
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  quo_q, quo_d;
  logic          ovr_q, ovr_d, dbz_q, dbz_d, vld_q, vld_d;

  logic [N-1:0] a_mag, b_mag;
  logic         a_neg, b_neg;

  q_absval #(.N(N)) u_abs_a (.x_i(i_dividend), .mag_o(a_mag), .sign_o(a_neg));
  q_absval #(.N(N)) u_abs_b (.x_i(i_divisor),  .mag_o(b_mag), .sign_o(b_neg));

  // The kept remainder is always below the divisor, so N bits hold it; the
  // shifted compare operand needs N+1 so the compare never wraps.
  logic [N:0]   rem_sh;
  logic         ge;
  logic [N-1:0] rem_sub;
  logic         mag_ovr;
  logic [N-1:0] mag_lo;

  assign rem_sh  = {rem_q, dvd_q[W-1]};
  assign ge      = rem_sh >= {1'b0, dsr_q};
  assign rem_sub = rem_sh[N-1:0] - dsr_q;
  assign mag_ovr = |dvd_q[W-1:N-1];
  assign mag_lo  = dvd_q[N-1:0];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    quo_d   = quo_q;
    ovr_d   = ovr_q;
    dbz_d   = dbz_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          sign_d  = a_neg ^ b_neg;
          dsr_d   = b_mag;
          dvd_d   = {a_mag, {Q{1'b0}}};
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = (b_mag == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        rem_d = ge ? rem_sub : rem_sh[N-1:0];
        dvd_d = {dvd_q[W-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        vld_d   = 1'b1;
        state_d = IDLE;
        dbz_d   = (dsr_q == '0);
        ovr_d   = 1'b1;
        // With a zero divisor the sign flag is the dividend sign and dvd_q
        // still holds |dividend|<<Q.
        if (dsr_q == '0)
          quo_d = (dvd_q == '0) ? '0 : (sign_q ? SAT_N : SAT_P);
        else if (mag_ovr)
          quo_d = sign_q ? SAT_N : SAT_P;
        else begin
          ovr_d = 1'b0;
          quo_d = sign_q ? -mag_lo : mag_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      quo_q   <= '0;
      ovr_q   <= 1'b0;
      dbz_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      quo_q   <= quo_d;
      ovr_q   <= ovr_d;
      dbz_q   <= dbz_d;
      vld_q   <= vld_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_valid    = vld_q;
  assign o_quotient = quo_q;
  assign o_ovr      = ovr_q;
  assign o_dbz      = dbz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed vector table, handshake/reset
// sequences, and randomized operands against an arithmetic reference model.
module tb_qdiv_seq;

  localparam int N = 32;
  localparam int Q = 18;
  localparam int LAT = N + Q + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_busy, o_valid, o_ovr, o_dbz;
  logic [31:0] o_quotient;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_busy(o_busy), .o_valid(o_valid), .o_quotient(o_quotient),
    .o_ovr(o_ovr), .o_dbz(o_dbz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovr;
    logic        dbz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer division of |a|*2^Q by |b|, truncated, then
  // signed, saturated, and the divide-by-zero rule.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic ovr, output logic dbz);
    longint          sa, sb;
    longint unsigned ma, mb, mag;
    bit              neg;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ma  = (sa < 0) ? longint'(-sa) : longint'(sa);
    mb  = (sb < 0) ? longint'(-sb) : longint'(sb);
    neg = (sa < 0) != (sb < 0);
    dbz = 1'b0;
    ovr = 1'b0;
    if (sb == 0) begin
      dbz = 1'b1;
      ovr = 1'b1;
      q = (sa > 0) ? 32'h7FFF_FFFF : (sa < 0) ? 32'h8000_0000 : 32'h0;
    end else begin
      mag = (ma << Q) / mb;
      if (mag >= 64'h8000_0000) begin
        ovr = 1'b1;
        q = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        q = neg ? 32'(-longint'(mag)) : 32'(mag);
      end
    end
  endfunction

  // Issues one request; optionally pulses i_start with other operands at CALC
  // cycle inj. Returns the result captured in the o_valid cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                        output logic [31:0] q, output logic ovr, output logic dbz,
                        output int lat, output logic busy_ok, output logic busy_end);
    @(negedge clk);
    i_start = 1'b1; i_dividend = a; i_divisor = b;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!o_valid && lat < 200) begin
      if (!o_busy) busy_ok = 1'b0;
      if (lat == inj) begin
        i_start = 1'b1; i_dividend = 32'h0004_0000; i_divisor = 32'h000C_0000;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    i_start = 1'b0;
    q = o_quotient; ovr = o_ovr; dbz = o_dbz; busy_end = o_busy;
  endtask

  task automatic check_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input int inj);
    logic [31:0] q, eq;
    logic ovr, dbz, eovr, edbz, bok, bend;
    int lat;
    ref_div(a, b, eq, eovr, edbz);
    run_op(a, b, inj, q, ovr, dbz, lat, bok, bend);
    chk({nm, ".lat"}, 64'(lat), (b == 0) ? 64'd1 : 64'(LAT));
    chk({nm, ".q"}, 64'(q), 64'(eq));
    chk({nm, ".ovr"}, 64'(ovr), 64'(eovr));
    chk({nm, ".dbz"}, 64'(dbz), 64'(edbz));
    chk({nm, ".busy"}, 64'(bok), 64'd1);
    chk({nm, ".busy_end"}, 64'(bend), 64'd0);
  endtask

  initial begin
    vec_t tbl[13];
    logic [31:0] q, rq;
    logic ovr, dbz, rovr, rdbz, bok, bend;
    int lat, vseen;

    tbl[0]  = '{32'h0018_0000, 32'h0008_0000, 32'h000C_0000, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFF4_0000, 32'h0008_0000, 32'hFFFA_0000, 1'b0, 1'b0};
    tbl[2]  = '{32'h0004_0000, 32'h000C_0000, 32'h0001_5555, 1'b0, 1'b0};
    tbl[3]  = '{32'hFFFF_FFFF, 32'h0008_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[4]  = '{32'h1000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[5]  = '{32'hF000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    tbl[6]  = '{32'h0014_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    tbl[8]  = '{32'hFFFC_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'h0008_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[10] = '{32'h8000_0000, 32'hFFFC_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[11] = '{32'h8000_0000, 32'h8000_0000, 32'h0004_0000, 1'b0, 1'b0};
    tbl[12] = '{32'hC000_0000, 32'h0004_0000, 32'hC000_0000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(o_busy), 64'd0);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.q", 64'(o_quotient), 64'd0);
    chk("rst.flags", 64'({o_ovr, o_dbz}), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].a, tbl[i].b, -1, q, ovr, dbz, lat, bok, bend);
      chk($sformatf("vec%0d.lat", i), 64'(lat), (tbl[i].b == 0) ? 64'd1 : 64'(LAT));
      chk($sformatf("vec%0d.q", i), 64'(q), 64'(tbl[i].q));
      chk($sformatf("vec%0d.ovr", i), 64'(ovr), 64'(tbl[i].ovr));
      chk($sformatf("vec%0d.dbz", i), 64'(dbz), 64'(tbl[i].dbz));
      chk($sformatf("vec%0d.busy", i), 64'(bok), 64'd1);
      ref_div(tbl[i].a, tbl[i].b, rq, rovr, rdbz);
      chk($sformatf("vec%0d.model", i), 64'({rq, rovr, rdbz}),
          64'({tbl[i].q, tbl[i].ovr, tbl[i].dbz}));
    end

    // one-cycle valid pulse, result held afterwards
    @(posedge clk); #1;
    chk("pulse.valid", 64'(o_valid), 64'd0);
    chk("pulse.hold", 64'(o_quotient), 64'hC000_0000);

    // start mid-CALC is ignored
    check_op("ignore", 32'h0018_0000, 32'h0008_0000, 10);
    @(posedge clk); #1;
    chk("ignore.idle", 64'(o_busy), 64'd0);

    // back-to-back: new start during the o_valid cycle
    check_op("b2b_a", 32'hFFF4_0000, 32'h0008_0000, -1);
    chk("b2b.valid_now", 64'(o_valid), 64'd1);
    check_op("b2b_b", 32'h0004_0000, 32'h000C_0000, -1);

    // reset mid-CALC abandons the division
    @(negedge clk);
    i_start = 1'b1; i_dividend = 32'h0018_0000; i_divisor = 32'h0008_0000;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rstcalc.busy_pre", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstcalc.busy", 64'(o_busy), 64'd0);
    chk("rstcalc.valid", 64'(o_valid), 64'd0);
    chk("rstcalc.q", 64'(o_quotient), 64'd0);
    chk("rstcalc.flags", 64'({o_ovr, o_dbz}), 64'd0);
    rst = 1'b0;
    vseen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_valid || o_busy) vseen++;
    end
    chk("rstcalc.no_valid", 64'(vseen), 64'd0);
    check_op("after_rst", 32'h0018_0000, 32'h0008_0000, -1);

    // randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 15) == 0) b = '0;
      check_op($sformatf("rnd%0d", i), a, b, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
